// File: rtl/dbf_pkg.sv
// Shared definitions for the per-channel receive beamformer: default widths,
// control states, delay LUT entry layout and pipeline latency.
package dbf_pkg;

  localparam int unsigned DEF_INPUT_WD = 14;
  localparam int unsigned DEF_APO_WD   = 16;
  localparam int unsigned DEF_ADDR_WD  = 12;
  localparam int unsigned DEF_BUF_LOG2 = 7;
  localparam int unsigned DEF_FRAC_WD  = 4;
  localparam int unsigned DEF_OUT_WD   = 32;

  localparam int unsigned PIPE_LAT = 4;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef struct packed {
    logic [DEF_BUF_LOG2-1:0] coarse;
    logic [DEF_FRAC_WD-1:0]  frac;
  } lut_entry_t;

endpackage

// File: rtl/dbf_channel_interp_if.sv
// Sample stream bundle of the beamformer channel: raw input samples in,
// beamformed samples out to the channel summer.
interface dbf_channel_interp_if
  import dbf_pkg::*;
#(
  parameter int unsigned INPUT_WD = DEF_INPUT_WD,
  parameter int unsigned OUT_WD   = DEF_OUT_WD
);

  logic signed [INPUT_WD-1:0] ch_in;
  logic                       ch_in_valid;
  logic signed [OUT_WD-1:0]   dbf_ch_dout;
  logic                       dbf_ch_dout_valid;

  modport master (
    output ch_in, ch_in_valid,
    input  dbf_ch_dout, dbf_ch_dout_valid
  );

  modport slave (
    input  ch_in, ch_in_valid,
    output dbf_ch_dout, dbf_ch_dout_valid
  );

endinterface

// File: rtl/dbf_delay_lut.sv
// Per-sample delay table: simple dual-port RAM, registered read,
// a read colliding with a write to the same address returns the old entry.
module dbf_delay_lut #(
  parameter int unsigned ADDR_WD = 12,
  parameter int unsigned DATA_WD = 11
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_WD-1:0] waddr,
  input  logic [DATA_WD-1:0] wdata,
  input  logic [ADDR_WD-1:0] raddr,
  output logic [DATA_WD-1:0] rdata
);

  logic [DATA_WD-1:0] mem [2**ADDR_WD];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dbf_channel_interp.sv
// Receive beamformer channel: LUT-driven coarse delay through a ring buffer,
// optional linear fine delay (DBF_FINE_DELAY_EN), apodisation, registered out.
module dbf_channel_interp
  import dbf_pkg::*;
#(
  parameter int unsigned INPUT_WD = DEF_INPUT_WD,
  parameter int unsigned APO_WD   = DEF_APO_WD,
  parameter int unsigned ADDR_WD  = DEF_ADDR_WD,
  parameter int unsigned BUF_LOG2 = DEF_BUF_LOG2,
  parameter int unsigned FRAC_WD  = DEF_FRAC_WD,
  parameter int unsigned OUT_WD   = DEF_OUT_WD,
  parameter int unsigned CH_ID    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  dbf_channel_interp_if.slave          bus,
  input  logic                         start,
  input  logic                         tx_en,
  input  logic [ADDR_WD-1:0]           line_len,
  input  logic signed [APO_WD-1:0]     apo_din,
  input  logic                         lut_we,
  input  logic [ADDR_WD-1:0]           lut_addr,
  input  logic [BUF_LOG2+FRAC_WD-1:0]  lut_wdata,
  output logic [INPUT_WD-1:0]          cd_dout,
  output logic                         busy,
  output logic                         delay_err,
  output logic [7:0]                   ch_id
);

  localparam int unsigned DEPTH = 2**BUF_LOG2;
  localparam int unsigned Y_WD  = INPUT_WD + 1;
  localparam int unsigned P_WD  = Y_WD + APO_WD;
  localparam logic [BUF_LOG2-1:0] MAX_D = BUF_LOG2'(DEPTH - 2);
  localparam logic [BUF_LOG2:0]   FULL  = (BUF_LOG2+1)'(DEPTH);

  typedef struct packed {
    logic [BUF_LOG2-1:0] coarse;
    logic [FRAC_WD-1:0]  frac;
  } entry_t;

  state_t state, state_nxt;
  logic   accept, kill;

  logic [BUF_LOG2-1:0]      wr_ptr;
  logic [ADDR_WD-1:0]       n;
  logic [BUF_LOG2:0]        fill;
  logic signed [APO_WD-1:0] apo;
  logic [PIPE_LAT-1:0]      vld;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    kill      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (start) begin
          kill = 1'b1;
        end else if (bus.ch_in_valid && !tx_en) begin
          accept = 1'b1;
          if (n == line_len) state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      n      <= '0;
      fill   <= '0;
      apo    <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        n    <= '0;
        fill <= '0;
        apo  <= apo_din;
      end else if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        n      <= n + 1'b1;
        if (fill != FULL) fill <= fill + 1'b1;
      end
    end
  end

  // S1: ring write, LUT read at n, capture write slot and fill including this sample
  logic [INPUT_WD-1:0] ring [DEPTH];
  logic [BUF_LOG2-1:0] p1_wp;
  logic [BUF_LOG2:0]   p1_fill;
  logic [BUF_LOG2+FRAC_WD-1:0] lut_rdata;

  always_ff @(posedge clk) begin
    if (accept) ring[wr_ptr] <= bus.ch_in;
  end

  dbf_delay_lut #(
    .ADDR_WD (ADDR_WD),
    .DATA_WD (BUF_LOG2 + FRAC_WD)
  ) u_lut (
    .clk   (clk),
    .we    (lut_we),
    .waddr (lut_addr),
    .wdata (lut_wdata),
    .raddr (n),
    .rdata (lut_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_wp   <= '0;
      p1_fill <= '0;
      vld     <= '0;
    end else begin
      if (accept) begin
        p1_wp   <= wr_ptr;
        p1_fill <= (fill == FULL) ? FULL : fill + 1'b1;
      end
      if (kill) vld <= '0;
      else      vld <= {vld[PIPE_LAT-2:0], accept};
    end
  end

  // S2: clamp coarse delay, fetch x[n-D] and x[n-D-1], zero while under-filled
  entry_t              ent;
  logic                clamp, under;
  logic [BUF_LOG2-1:0] d, a0;
  logic signed [INPUT_WD-1:0] s0;

  assign ent   = entry_t'(lut_rdata);
  assign clamp = ent.coarse > MAX_D;
  assign d     = clamp ? MAX_D : ent.coarse;
  assign under = p1_fill < ((BUF_LOG2+1)'(d) + (BUF_LOG2+1)'(2));
  assign a0    = p1_wp - d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0        <= '0;
      delay_err <= 1'b0;
    end else begin
      if (vld[0]) s0 <= under ? '0 : ring[a0];
      if (start)                  delay_err <= 1'b0;
      else if (vld[0] && clamp)   delay_err <= 1'b1;
    end
  end

  // S3: fine delay or plain pass-through; either way one register stage
  logic signed [Y_WD-1:0] y_nxt, y;

`ifdef DBF_FINE_DELAY_EN
  localparam int unsigned F_WD = Y_WD + FRAC_WD + 1;
  logic signed [INPUT_WD-1:0] s1;
  logic [FRAC_WD-1:0]         p2_frac;
  logic signed [Y_WD-1:0]     diff;
  logic signed [F_WD-1:0]     fprod, fshift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= '0;
      p2_frac <= '0;
    end else if (vld[0]) begin
      s1      <= under ? '0 : ring[a0 - 1'b1];
      p2_frac <= ent.frac;
    end
  end

  assign diff   = Y_WD'(s1) - Y_WD'(s0);
  assign fprod  = F_WD'(diff) * F_WD'($signed({1'b0, p2_frac}));
  assign fshift = fprod >>> FRAC_WD;
  assign y_nxt  = Y_WD'(s0) + Y_WD'(fshift);
`else
  logic unused_frac;
  assign unused_frac = ^ent.frac;
  assign y_nxt       = Y_WD'(s0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y       <= '0;
      cd_dout <= '0;
    end else if (vld[1]) begin
      y       <= y_nxt;
      cd_dout <= s0;
    end
  end

  // S4: apodisation, sign-extended to the summer width
  logic signed [P_WD-1:0] prod;
  assign prod = P_WD'(y) * P_WD'(apo);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         bus.dbf_ch_dout <= '0;
    else if (vld[2]) bus.dbf_ch_dout <= OUT_WD'(prod);
  end

  assign bus.dbf_ch_dout_valid = vld[PIPE_LAT-1];
  assign busy                  = (state == RUN);
  assign ch_id                 = 8'(CH_ID);

endmodule

// File: tb/tb_dbf_channel_interp.sv
// Scoreboard bench for dbf_channel_interp: a sample-history reference model
// pushes expected outputs and arrival cycles; a negedge monitor checks them.
module tb_dbf_channel_interp;
  import dbf_pkg::*;

  localparam int unsigned IW = 14, AW = 16, ADW = 12, BL = 7, FW = 4, OW = 32, CH = 5;
  localparam int DMAX = 126;
  localparam int FULLN = 128;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, tx_en = 1'b0, lut_we = 1'b0;
  logic [ADW-1:0]         line_len = '0, lut_addr = '0;
  logic signed [AW-1:0]   apo_din = '0;
  logic [BL+FW-1:0]       lut_wdata = '0;
  logic [IW-1:0]          cd_dout;
  logic                   busy, delay_err;
  logic [7:0]             ch_id;

  dbf_channel_interp_if #(.INPUT_WD(IW), .OUT_WD(OW)) bus ();

  dbf_channel_interp #(
    .INPUT_WD (IW), .APO_WD (AW), .ADDR_WD (ADW), .BUF_LOG2 (BL),
    .FRAC_WD (FW), .OUT_WD (OW), .CH_ID (CH)
  ) dut (
    .clk (clk), .rst (rst), .bus (bus), .start (start), .tx_en (tx_en),
    .line_len (line_len), .apo_din (apo_din), .lut_we (lut_we),
    .lut_addr (lut_addr), .lut_wdata (lut_wdata), .cd_dout (cd_dout),
    .busy (busy), .delay_err (delay_err), .ch_id (ch_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0, errors = 0;

  typedef struct {
    longint val;
    int     at;
  } exp_t;
  exp_t sbq[$];

  int hist [4096];
  int lut_c[4096];
  int lut_f[4096];
  int m_n, m_len, m_apo;
  bit m_busy = 0, m_clamp = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.dbf_ch_dout_valid) begin
      if (sbq.size() == 0) begin
        check("valid_without_expected", longint'(bus.dbf_ch_dout_valid), 0);
      end else begin
        e = sbq.pop_front();
        check("dout", longint'(bus.dbf_ch_dout), e.val);
        check("latency", cyc, e.at);
      end
    end
  end

  // Output for line sample n from the accepted-sample history of this line.
  function automatic longint model_out(input int n);
    int fill, d, s0, s1, y;
    fill = (n + 1 > FULLN) ? FULLN : n + 1;
    d = lut_c[n];
    if (d > DMAX) begin
      d = DMAX;
      m_clamp = 1;
    end
    if (fill < d + 2) return 0;
    s0 = hist[n-d];
    s1 = hist[n-d-1];
`ifdef DBF_FINE_DELAY_EN
    y = s0 + (((s1 - s0) * lut_f[n]) >>> FW);
`else
    y = s0 + 0 * s1;
`endif
    return longint'(y) * m_apo;
  endfunction

  task automatic drive(input bit v, input int x, input bit tx,
                       input bit we = 0, input int wa = 0, input int wc = 0, input int wf = 0);
    lut_entry_t ent;
    exp_t e;
    ent.coarse      = BL'(wc);
    ent.frac        = FW'(wf);
    bus.ch_in       = IW'(x);
    bus.ch_in_valid = v;
    tx_en           = tx;
    lut_we          = we;
    lut_addr        = ADW'(wa);
    lut_wdata       = ent;
    if (v && !tx && m_busy) begin
      hist[m_n] = x;
      e.val = model_out(m_n);
      e.at  = cyc + 4;
      sbq.push_back(e);
      if (m_n == m_len) m_busy = 0;
      m_n++;
    end
    if (we) begin
      lut_c[wa] = wc;
      lut_f[wa] = wf;
    end
    @(posedge clk); #1;
    bus.ch_in_valid = 1'b0;
    tx_en           = 1'b0;
    lut_we          = 1'b0;
  endtask

  task automatic lut_write(input int a, input int c, input int f);
    drive(0, 0, 0, 1, a, c, f);
  endtask

  task automatic start_line(input int len, input int apo);
    bit was;
    was      = m_busy;
    line_len = ADW'(len);
    apo_din  = AW'(apo);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (was) sbq.delete();
    m_busy = 1; m_n = 0; m_len = len; m_apo = apo; m_clamp = 0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", sbq.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int idx, x, c;
    bus.ch_in       = '0;
    bus.ch_in_valid = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", longint'(bus.dbf_ch_dout), 0);
    check("rst_valid", bus.dbf_ch_dout_valid, 0);
    check("rst_cd", cd_dout, 0);
    check("rst_busy", busy, 0);
    check("rst_delay_err", delay_err, 0);
    check("ch_id", ch_id, CH);
    rst = 1'b0;
    @(posedge clk); #1;

    // coarse 3 / frac 8 on a ramp, with random gaps and a tx_en window
    for (int a = 0; a < 48; a++) lut_write(a, 3, 8);
    start_line(39, 1);
    idx = 0;
    while (m_busy) begin
      if (idx == 20) begin
        for (int k = 0; k < 5; k++) drive(1, 9999, 1);
        check("busy_mid_line", busy, 1);
      end
      if ($urandom_range(0, 3) != 0) begin
        drive(1, 16 * idx, 0);
        idx++;
      end else begin
        drive(0, 0, 0);
      end
    end
    check("busy_after_line", busy, 0);
    wait_drain();
    check("delay_err_ramp", delay_err, 0);

    // apodisation with a constant input
    for (int a = 0; a < 20; a++) lut_write(a, 0, 0);
    start_line(19, -3);
    for (int k = 0; k < 20; k++) drive(1, 100, 0);
    wait_drain();

    // line length: exactly ten accepts, an eleventh sample is ignored
    start_line(9, 7);
    for (int k = 0; k < 10; k++) drive(1, int'($urandom_range(0, 16383)) - 8192, 0);
    check("busy_after_10", busy, 0);
    drive(1, 55, 0);
    wait_drain();
    repeat (8) drive(0, 0, 0);

    // random delays across buffer wrap, forced clamp, LUT read/write collisions
    for (int a = 0; a < 300; a++) begin
      c = ($urandom_range(0, 9) == 0) ? 127 : int'($urandom_range(0, 127));
      if (a == 150) c = 127;
      lut_write(a, c, int'($urandom_range(0, 15)));
    end
    start_line(299, int'($urandom_range(0, 65535)) - 32768);
    while (m_busy) begin
      x = int'($urandom_range(0, 16383)) - 8192;
      if ($urandom_range(0, 4) == 0)
        drive(0, 0, 0);
      else if ($urandom_range(0, 7) == 0)
        drive(1, x, 0, 1, m_n, int'($urandom_range(0, 127)), int'($urandom_range(0, 15)));
      else
        drive(1, x, 0);
    end
    wait_drain();
    check("delay_err_clamp", delay_err, longint'(m_clamp));

    // restart at the third accept kills in-flight outputs and restarts n
    for (int a = 0; a < 16; a++) lut_write(a, 1, 0);
    start_line(15, 1);
    check("delay_err_cleared", delay_err, 0);
    for (int k = 0; k < 3; k++) drive(1, 16 * k, 0);
    start_line(15, 2);
    for (int k = 0; k < 8; k++) drive(1, 16 * k + 3, 0);
    check("busy_before_rst", busy, 1);

    // asynchronous reset mid-line
    #2 rst = 1'b1;
    #1;
    check("midrst_dout", longint'(bus.dbf_ch_dout), 0);
    check("midrst_valid", bus.dbf_ch_dout_valid, 0);
    check("midrst_cd", cd_dout, 0);
    check("midrst_busy", busy, 0);
    check("midrst_delay_err", delay_err, 0);
    sbq.delete();
    m_busy = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) drive(1, 77, 0);
    repeat (10) drive(0, 0, 0);
    check("busy_after_rst", busy, 0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
